// File: rtl/mem_layout_pkg.sv
// Mem-map layout constants shared by the fabric-side register writers,
// plus the state encoding of the big-register writer.
package mem_layout_pkg;

  localparam int BUFF_TIMESTAMP_WIDTH = 32;
  localparam int WD_DATA_WIDTH        = 16;
  localparam int BUFF_SAMPLES         = BUFF_TIMESTAMP_WIDTH / WD_DATA_WIDTH;
  localparam int MEM_SIZE             = 256;
  localparam int BUFF_TIME_BASE_ID    = 27;
  localparam int BUFF_TIME_VALID_ID   = BUFF_TIME_BASE_ID + BUFF_SAMPLES;

  localparam logic [15:0] RTL_VALID_WORD = 16'h0001;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITE       = 2'd1,
    WRITE_VALID = 2'd2,
    WAIT_PS     = 2'd3
  } state_t;

endpackage

// File: rtl/rtl_bigreg_writer.sv
// Publishes a wide value as consecutive mem-map words followed by a valid
// entry, then waits for the PS read before publishing the next value.
module rtl_bigreg_writer #(
  parameter int DATA_WIDTH = mem_layout_pkg::BUFF_TIMESTAMP_WIDTH,
  parameter int WORD_WIDTH = mem_layout_pkg::WD_DATA_WIDTH,
  parameter int SAMPLES    = DATA_WIDTH / WORD_WIDTH,
  parameter int MEM_SIZE   = mem_layout_pkg::MEM_SIZE,
  parameter int BASE_ID    = mem_layout_pkg::BUFF_TIME_BASE_ID,
  parameter int VALID_ID   = BASE_ID + SAMPLES,
  localparam int IDW       = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] bigreg_in,
  input  logic                  bigreg_valid_in,
  output logic                  bigreg_ready_out,
  output logic [IDW-1:0]        mem_wr_id_out,
  output logic [WORD_WIDTH-1:0] mem_wr_data_out,
  output logic                  mem_wr_valid_out,
  input  logic                  mem_wr_ready_in,
  input  logic                  ps_read_done_in,
  output logic                  busy_out,
  output logic [7:0]            overwrite_cnt_out
);
  import mem_layout_pkg::*;

  localparam int KW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [7:0]            ovf_cnt_q, ovf_cnt_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [IDW-1:0]        wr_id_q, wr_id_d;
  logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  ready_q;
  logic                  wr_fire;

  assign wr_fire = wr_valid_q && mem_wr_ready_in;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    ovf_cnt_d = ovf_cnt_q;

    // Busy-time captures go to the depth-1 latest-wins pending slot.
    if (bigreg_valid_in && state_q != IDLE &&
        !(state_q == WAIT_PS && ps_read_done_in)) begin
      pend_d   = bigreg_in;
      pend_v_d = 1'b1;
      if (pend_v_q && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (bigreg_valid_in) begin
          hold_d  = bigreg_in;
          k_d     = '0;
          state_d = WRITE;
        end else if (pend_v_q) begin
          hold_d   = pend_q;
          pend_v_d = 1'b0;
          k_d      = '0;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (wr_fire) begin
          if (k_q == KW'(SAMPLES - 1)) state_d = WRITE_VALID;
          else                         k_d     = k_q + KW'(1);
        end
      end
      WRITE_VALID: begin
        if (wr_fire) state_d = WAIT_PS;
      end
      WAIT_PS: begin
        // A fresh value beats the older pending one, which stays queued.
        if (ps_read_done_in) begin
          if (bigreg_valid_in) begin
            hold_d  = bigreg_in;
            k_d     = '0;
            state_d = WRITE;
          end else if (pend_v_q) begin
            hold_d   = pend_q;
            pend_v_d = 1'b0;
            k_d      = '0;
            state_d  = WRITE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_valid_d = 1'b0;
    wr_id_d    = '0;
    wr_data_d  = '0;
    case (state_d)
      WRITE: begin
        wr_valid_d = 1'b1;
        wr_id_d    = IDW'(BASE_ID + int'(k_d));
        wr_data_d  = hold_d[int'(k_d)*WORD_WIDTH +: WORD_WIDTH];
      end
      WRITE_VALID: begin
        wr_valid_d = 1'b1;
        wr_id_d    = IDW'(VALID_ID);
        wr_data_d  = WORD_WIDTH'(RTL_VALID_WORD);
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      hold_q     <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      ovf_cnt_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_id_q    <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      ovf_cnt_q  <= ovf_cnt_d;
      wr_valid_q <= wr_valid_d;
      wr_id_q    <= wr_id_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      ready_q    <= 1'b1;
    end
  end

  assign bigreg_ready_out  = ready_q;
  assign mem_wr_valid_out  = wr_valid_q;
  assign mem_wr_id_out     = wr_id_q;
  assign mem_wr_data_out   = wr_data_q;
  assign busy_out          = busy_q;
  assign overwrite_cnt_out = ovf_cnt_q;

endmodule

// File: tb/tb_rtl_bigreg_writer.sv
// Directed bench for rtl_bigreg_writer: per-cycle vector table plus
// hand-written multi-cycle sequences, with a write-stream scoreboard.
module tb_rtl_bigreg_writer;

  logic        clk;
  logic        rst_n;
  logic [31:0] bigreg_in;
  logic        bigreg_valid_in;
  logic        bigreg_ready_out;
  logic [7:0]  mem_wr_id_out;
  logic [15:0] mem_wr_data_out;
  logic        mem_wr_valid_out;
  logic        mem_wr_ready_in;
  logic        ps_read_done_in;
  logic        busy_out;
  logic [7:0]  overwrite_cnt_out;

  int n_tests;
  int n_fail;

  // {id, data} of every write the arbiter is expected to accept, in order.
  logic [23:0] exp_q[$];

  typedef struct {
    logic        vld;
    logic [31:0] din;
    logic        rdy;
    logic        done;
    logic        exp_valid;
    logic [7:0]  exp_id;
    logic [15:0] exp_data;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[16];

  rtl_bigreg_writer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bigreg_in         (bigreg_in),
    .bigreg_valid_in   (bigreg_valid_in),
    .bigreg_ready_out  (bigreg_ready_out),
    .mem_wr_id_out     (mem_wr_id_out),
    .mem_wr_data_out   (mem_wr_data_out),
    .mem_wr_valid_out  (mem_wr_valid_out),
    .mem_wr_ready_in   (mem_wr_ready_in),
    .ps_read_done_in   (ps_read_done_in),
    .busy_out          (busy_out),
    .overwrite_cnt_out (overwrite_cnt_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: inputs change just after posedge, so negedge sees the
  // values that the next posedge will act on.
  always @(negedge clk) begin
    if (rst_n && mem_wr_valid_out && mem_wr_ready_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {8'h0, mem_wr_id_out, mem_wr_data_out}, 32'hFFFF_FFFF);
      end else begin
        chk("write_stream", {8'h0, mem_wr_id_out, mem_wr_data_out}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks
  task automatic cyc(input logic vld, input logic [31:0] din, input logic done);
    bigreg_valid_in = vld;
    bigreg_in       = din;
    ps_read_done_in = done;
    @(posedge clk); #1;
    bigreg_valid_in = 1'b0;
    ps_read_done_in = 1'b0;
  endtask

  task automatic push_value(input logic [31:0] v);
    exp_q.push_back({8'd27, v[15:0]});
    exp_q.push_back({8'd28, v[31:16]});
    exp_q.push_back({8'd29, 16'h0001});
  endtask

  task automatic drain(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0 && !mem_wr_valid_out) break;
      @(posedge clk); #1;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_valid_low"}, mem_wr_valid_out, 1'b0);
    chk({name, "_busy_wait_ps"}, busy_out, 1'b1);
  endtask

  task automatic set_vec(input int i, input logic vld, input logic [31:0] din,
                         input logic rdy, input logic done, input logic ev,
                         input logic [7:0] eid, input logic [15:0] ed, input logic eb);
    vecs[i].vld = vld;       vecs[i].din = din;
    vecs[i].rdy = rdy;       vecs[i].done = done;
    vecs[i].exp_valid = ev;  vecs[i].exp_id = eid;
    vecs[i].exp_data = ed;   vecs[i].exp_busy = eb;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //          vld  din           rdy  done ev  id     data      busy
    set_vec( 0, 1, 32'hDEAD_BEEF, 1,   0,   1,  8'd27, 16'hBEEF, 1);
    set_vec( 1, 0, 32'h0,         1,   0,   1,  8'd28, 16'hDEAD, 1);
    set_vec( 2, 0, 32'h0,         1,   0,   1,  8'd29, 16'h0001, 1);
    set_vec( 3, 0, 32'h0,         1,   0,   0,  8'd0,  16'h0,    1);
    set_vec( 4, 0, 32'h0,         1,   0,   0,  8'd0,  16'h0,    1);
    set_vec( 5, 0, 32'h0,         1,   1,   0,  8'd0,  16'h0,    0);
    set_vec( 6, 0, 32'h0,         1,   1,   0,  8'd0,  16'h0,    0);
    set_vec( 7, 1, 32'h0BAD_F00D, 1,   0,   1,  8'd27, 16'hF00D, 1);
    set_vec( 8, 0, 32'h0,         1,   0,   1,  8'd28, 16'h0BAD, 1);
    set_vec( 9, 0, 32'h0,         0,   0,   1,  8'd28, 16'h0BAD, 1);
    set_vec(10, 0, 32'h0,         0,   0,   1,  8'd28, 16'h0BAD, 1);
    set_vec(11, 0, 32'h0,         0,   0,   1,  8'd28, 16'h0BAD, 1);
    set_vec(12, 0, 32'h0,         0,   0,   1,  8'd28, 16'h0BAD, 1);
    set_vec(13, 0, 32'h0,         0,   0,   1,  8'd28, 16'h0BAD, 1);
    set_vec(14, 0, 32'h0,         1,   0,   1,  8'd29, 16'h0001, 1);
    set_vec(15, 0, 32'h0,         1,   0,   0,  8'd0,  16'h0,    1);

    rst_n           = 1'b0;
    bigreg_in       = '0;
    bigreg_valid_in = 1'b0;
    mem_wr_ready_in = 1'b1;
    ps_read_done_in = 1'b0;
    #1;
    chk("rst_ready", bigreg_ready_out, 1'b0);
    chk("rst_valid", mem_wr_valid_out, 1'b0);
    chk("rst_id", mem_wr_id_out, 8'd0);
    chk("rst_data", mem_wr_data_out, 16'd0);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_ovf", overwrite_cnt_out, 8'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ready_before_edge", bigreg_ready_out, 1'b0);
    @(posedge clk); #1;
    chk("ready_after_edge", bigreg_ready_out, 1'b1);

    // Basic publish, stray read pulse in IDLE, back-pressure on word 1
    push_value(32'hDEAD_BEEF);
    push_value(32'h0BAD_F00D);
    for (int i = 0; i < 16; i++) begin
      bigreg_valid_in = vecs[i].vld;
      bigreg_in       = vecs[i].din;
      mem_wr_ready_in = vecs[i].rdy;
      ps_read_done_in = vecs[i].done;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), mem_wr_valid_out, vecs[i].exp_valid);
      chk($sformatf("vec%0d_busy", i), busy_out, vecs[i].exp_busy);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_id", i), mem_wr_id_out, vecs[i].exp_id);
        chk($sformatf("vec%0d_data", i), mem_wr_data_out, vecs[i].exp_data);
      end
    end
    bigreg_valid_in = 1'b0;
    ps_read_done_in = 1'b0;
    mem_wr_ready_in = 1'b1;
    chk("table_writes_seen", exp_q.size(), 0);

    // Overwrite: three captures in WAIT_PS, latest wins
    cyc(1'b1, 32'h1, 1'b0);
    cyc(1'b1, 32'h2, 1'b0);
    cyc(1'b1, 32'h3, 1'b0);
    chk("ovf_cnt_2", overwrite_cnt_out, 8'd2);
    chk("ovf_still_wait", busy_out, 1'b1);
    push_value(32'h3);
    cyc(1'b0, 32'h0, 1'b1);
    drain("ovf_publish", 20);

    // Simultaneous read-done and capture: new value first, pending after
    cyc(1'b1, 32'hA, 1'b0);
    push_value(32'hB);
    cyc(1'b1, 32'hB, 1'b1);
    drain("simul_b", 20);
    push_value(32'hA);
    cyc(1'b0, 32'h0, 1'b1);
    drain("simul_a", 20);
    cyc(1'b0, 32'h0, 1'b1);
    chk("simul_idle", busy_out, 1'b0);
    chk("simul_ovf", overwrite_cnt_out, 8'd2);

    // Reset after the first word of a publish
    exp_q.push_back({8'd27, 16'h5678});
    cyc(1'b1, 32'h1234_5678, 1'b0);
    chk("mid_word0_id", mem_wr_id_out, 8'd27);
    @(posedge clk); #1;
    chk("mid_word1_id", mem_wr_id_out, 8'd28);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", mem_wr_valid_out, 1'b0);
    chk("mid_rst_id", mem_wr_id_out, 8'd0);
    chk("mid_rst_data", mem_wr_data_out, 16'd0);
    chk("mid_rst_busy", busy_out, 1'b0);
    chk("mid_rst_ready", bigreg_ready_out, 1'b0);
    chk("mid_rst_ovf", overwrite_cnt_out, 8'd0);
    chk("mid_rst_word0_seen", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_no_write", mem_wr_valid_out, 1'b0);
    push_value(32'hCAFE_0042);
    cyc(1'b1, 32'hCAFE_0042, 1'b0);
    drain("post_rst", 20);
    cyc(1'b0, 32'h0, 1'b1);
    chk("post_rst_idle", busy_out, 1'b0);

    // Saturation: 300 captures during WAIT_PS
    push_value(32'h55);
    cyc(1'b1, 32'h55, 1'b0);
    drain("sat_first", 20);
    for (int i = 0; i < 300; i++) cyc(1'b1, 32'(i), 1'b0);
    chk("sat_cnt", overwrite_cnt_out, 8'd255);
    push_value(32'd299);
    cyc(1'b0, 32'h0, 1'b1);
    drain("sat_latest", 20);
    cyc(1'b0, 32'h0, 1'b1);
    chk("sat_idle", busy_out, 1'b0);
    chk("sat_cnt_hold", overwrite_cnt_out, 8'd255);

    repeat (2) @(posedge clk);
    chk("final_no_writes_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rtl_bigreg_writer.md
Name: rtl_bigreg_writer

Overview:
- Fabric-side writer for RTL_BIGREG mem-map registers. The first user is the 32-bit buffer timestamp.
- Takes a wide value from RTL logic and splits it into WD_DATA_WIDTH words. Writes each word to the consecutive mem-map IDs BASE_ID..BASE_ID+SAMPLES-1, then writes the VALID_ID entry.
- After the valid write it holds off further writes until the PS has read the register.
- Sits between the producer (buffer timestamp logic) and the mem-map write arbiter. This is the reverse path of the PS_BIGREG collectors.

Parameters:
- DATA_WIDTH, 32 (BUFF_TIMESTAMP_WIDTH), width of the wide register.
- WORD_WIDTH, 16 (WD_DATA_WIDTH), width of one mem-map entry.
- SAMPLES, DATA_WIDTH/WORD_WIDTH (2), number of mem-map entries per value. Must be an integer ≥1.
- MEM_SIZE, 256, mem-map depth. ID width is IDW=$clog2(MEM_SIZE).
- BASE_ID, 27 (BUFF_TIME_BASE_ID), first data entry.
- VALID_ID, BASE_ID+SAMPLES (29), valid entry.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- bigreg_in  in  DATA_WIDTH  value to publish
- bigreg_valid_in  in  1  one-cycle strobe: capture bigreg_in
- bigreg_ready_out  out  1  always 1 after reset; the block never back-pressures the producer
- mem_wr_id_out  out  IDW  mem-map ID being written
- mem_wr_data_out  out  WORD_WIDTH  data for that ID
- mem_wr_valid_out  out  1  write request
- mem_wr_ready_in  in  1  arbiter accepts; transfer occurs when valid and ready are both high
- ps_read_done_in  in  1  pulse from the mem map when the PS reads VALID_ID (fresh bit cleared)
- busy_out  out  1  high in any state other than IDLE
- overwrite_cnt_out  out  8  saturating count of pending values that were replaced before being published

Behaviour:
- Reset values (asynchronous, active-low):
  - state = IDLE; all mem_wr_* outputs = 0; busy_out = 0; overwrite_cnt_out = 0.
  - Holding and pending registers cleared; pending_v = 0.
  - bigreg_ready_out = 0 while rst_n is low, and 1 from the first clk edge after release.
- States:
  - IDLE:
    - On bigreg_valid_in, latch bigreg_in into hold, set k = 0 and go to WRITE.
    - Otherwise, if pending_v is set, move pending into hold, clear pending_v and go to WRITE.
  - WRITE:
    - mem_wr_valid_out = 1, mem_wr_id_out = BASE_ID+k, mem_wr_data_out = hold[k*WORD_WIDTH +: WORD_WIDTH]. Least-significant word goes first.
    - On a handshake, k increments. The handshake with k = SAMPLES-1 moves the block to WRITE_VALID.
    - Outputs stay stable until mem_wr_ready_in is seen (AXI-style, no retraction).
  - WRITE_VALID:
    - mem_wr_valid_out = 1, mem_wr_id_out = VALID_ID, mem_wr_data_out = 1.
    - On a handshake, go to WAIT_PS.
  - WAIT_PS:
    - mem_wr_valid_out = 0.
    - On ps_read_done_in: if pending_v is set, move pending into hold, clear pending_v and go to WRITE; otherwise go to IDLE.
- Capture while busy:
  - A bigreg_valid_in in WRITE, WRITE_VALID or WAIT_PS writes the pending register and sets pending_v. The latest value wins.
  - If pending_v was already set, overwrite_cnt_out increments, saturating at 255.
  - hold is never modified mid-publish, so the words of one value are never torn.
- Simultaneous events:
  - WAIT_PS with ps_read_done_in and bigreg_valid_in in the same cycle: hold takes bigreg_in, any existing pending value stays pending (it is older), and the block goes to WRITE.
  - IDLE with bigreg_valid_in and pending_v both set: this cannot occur, because pending is only set while busy and is drained on leaving WAIT_PS.
- ps_read_done_in outside WAIT_PS is ignored.
- Latency:
  - From the bigreg_valid_in cycle in IDLE, the first write request appears on the next cycle.
  - With mem_wr_ready_in held high, the full publish takes SAMPLES+1 cycles.
- Reset mid-publish aborts immediately. Entries already written are left in the mem map; VALID_ID is not written. The mem map's own reset clears them.

Decomposition:
- Constants come from mem_layout_pkg: BUFF_TIME_BASE_ID, BUFF_TIME_VALID_ID, BUFF_SAMPLES, WD_DATA_WIDTH, MEM_SIZE.
- Add to that package:
  - state typedef enum {IDLE, WRITE, WRITE_VALID, WAIT_PS}, 2 bits;
  - constant RTL_VALID_WORD = 16'h0001.
- No sub-module. The pending/hold pair is inline; it is a degenerate depth-1 latest-wins buffer.

Test Plan:
- Basic publish: reset, then bigreg_in = 32'hDEAD_BEEF with mem_wr_ready_in tied 1 -> writes (27, 16'hBEEF), (28, 16'hDEAD), (29, 16'h0001) on 3 consecutive cycles, then busy_out stays high until the ps_read_done_in pulse, then IDLE.
- Back-pressure: mem_wr_ready_in low for 5 cycles during the second word -> ID 28 and data 16'hDEAD held stable for all 5 cycles, no duplicate or skipped ID.
- Overwrite: while in WAIT_PS send 32'h1, 32'h2, 32'h3 -> overwrite_cnt_out = 2; after ps_read_done_in the block publishes 32'h3 (27: 16'h0003, 28: 16'h0000, 29: 16'h0001).
- Simultaneous: in WAIT_PS, pending = 32'hA, and ps_read_done_in together with bigreg_valid_in = 32'hB -> publishes 32'hB first, then after the next ps_read_done_in publishes 32'hA.
- Reset mid-operation: assert rst_n low after the first word of 32'h1234_5678 -> all outputs 0 asynchronously, no write to ID 29, overwrite_cnt_out = 0, and a fresh publish works after release.
- Saturation: 300 captures while in WAIT_PS -> overwrite_cnt_out = 255.
